serial_sub: RTL and testbench

//   Bit-serial WIDTH-bit subtractor; the inverse operation to the adder family.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_sub_sub1bit.sv | 28 ++
 rtl/serial_sub.sv | 141 ++++++++++++++
 tb/tb_serial_sub.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types for the bit-serial subtractor: the FSM state
//                encoding used by serial_sub.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  // Explicit encodings. The unused value 2'd3 is treated as illegal and
  // recovers to ST_IDLE in the top-level next-state logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_sub1bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_sub1bit
//  Description : Combinational 1-bit full subtractor, the mirror of the 1-bit
//                adder cell. Computes x - y - bi.
//  Ports       : x  (in)  minuend bit
//                y  (in)  subtrahend bit
//                bi (in)  borrow in
//                d  (out) difference bit
//                bo (out) borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_sub1bit
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when x < y, or when x == y and a borrow is already pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : serial_sub_sub1bit
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub
//  Description : Bit-serial WIDTH-bit subtractor. diff = (a - b - b_in) mod
//                2^WIDTH computed LSB first, one bit per clock, through a
//                single full-subtractor cell and a borrow flop.
//  Ports       : clk   (in)  clock, rising edge
//                rst   (in)  synchronous reset, active-high
//                start (in)  request; a, b, b_in sampled when accepted
//                a     (in)  minuend, WIDTH bits
//                b     (in)  subtrahend, WIDTH bits
//                b_in  (in)  borrow in
//                busy  (out) high while an operation is in progress
//                done  (out) one-cycle pulse, diff/b_out just updated
//                diff  (out) result, held until the next done
//                b_out (out) borrow out, 1 iff a < b + b_in
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] r_next;

  serial_sub_sub1bit u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result register after this cycle's bit enters at the MSB; on the last
  // RUN cycle this is the complete difference.
  assign r_next = {cell_d, r_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = b_in;
          count_d = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d  = r_next;
        brw_d   = cell_bo;
        count_d = count_q + ONE;
        if (count_q == LAST) begin
          diff_d  = r_next;
          b_out_d = cell_bo;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub
//  Description : Self-checking bench for serial_sub (WIDTH=8): directed
//                vector table, multi-cycle corner sequences, random and
//                back-to-back operations against a 9-bit arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         b_out;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  // {borrow, diff} as a 9-bit two's-complement difference.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; n is the cycle count since the accepting edge.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic bi, input logic [W-1:0] ed, input logic eb);
    int n;
    a = x; b = y; b_in = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~x; b = ~y; b_in = ~bi;   // operands may change after acceptance
    chk({nm, " busy"}, busy, 1);
    wait_done(n);
    chk({nm, " latency"}, n, W + 1);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " b_out"}, b_out, eb);
    tick();
    chk({nm, " done pulse"}, done, 0);
    chk({nm, " idle busy"}, busy, 0);
  endtask

  initial begin
    vec_t tbl[5];
    logic [W:0] r;
    logic [31:0] rnd;
    logic [W-1:0] qa[$], qb[$];
    logic qi[$];
    int n;
    bit seen;

    tbl[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, exp_diff: 8'h02, exp_bout: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, exp_diff: 8'hFE, exp_bout: 1'b1};
    tbl[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, exp_diff: 8'hFF, exp_bout: 1'b1};
    tbl[3] = '{a: 8'hFF, b: 8'hFF, bin: 1'b0, exp_diff: 8'h00, exp_bout: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h01, bin: 1'b1, exp_diff: 8'h7E, exp_bout: 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset b_out", b_out, 0);

    // Directed vectors
    for (int i = 0; i < 5; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
             tbl[i].exp_diff, tbl[i].exp_bout);

    // Start while busy is ignored
    a = 8'h10; b = 8'h01; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();                       // now in RUN cycle 3
    a = 8'hAA; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ignore latency", n + 3, W + 1);
    chk("ignore diff", diff, 8'h0F);
    chk("ignore b_out", b_out, 0);
    tick();
    chk("ignore idle", busy, 0);

    // Reset mid-RUN aborts the operation
    a = 8'h20; b = 8'h01; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();               // now in RUN cycle 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort b_out", b_out, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("abort no done", seen, 0);
    run_op("after abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

    // Random operations with idle gaps
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      logic bi;
      rnd = $urandom;
      x = rnd[7:0]; y = rnd[15:8]; bi = rnd[16];
      r = ref_sub(x, y, bi);
      run_op($sformatf("rnd%0d", i), x, y, bi, r[W-1:0], r[W]);
    end

    // Back-to-back: start held high, new operands presented at each done
    for (int i = 0; i < 12; i++) begin
      rnd = $urandom;
      qa.push_back(rnd[7:0]); qb.push_back(rnd[15:8]); qi.push_back(rnd[16]);
    end
    a = qa[0]; b = qb[0]; b_in = qi[0]; start = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i + 1 < 12) begin
        a = qa[i+1]; b = qb[i+1]; b_in = qi[i+1];
      end else begin
        start = 1'b0;
        a = '0; b = '0; b_in = 1'b0;
      end
      wait_done(n);
      r = ref_sub(qa[i], qb[i], qi[i]);
      chk($sformatf("b2b%0d latency", i), n, W + 1);
      chk($sformatf("b2b%0d diff", i), diff, r[W-1:0]);
      chk($sformatf("b2b%0d b_out", i), b_out, r[W]);
      tick();
    end
    chk("b2b final idle", busy, 0);
    chk("b2b final done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_sub
`default_nettype wire
